// File: rtl/detector_pkg.sv
// Shared definitions for the SSVEP lock-in detector.
// Holds the FSM state encoding, default geometry constants (also used by the stimulus generator)
// and the accumulator width derivation.
package detector_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArm   = 2'd1,
      StAccum = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_M         = 64;
   localparam int unsigned DEFAULT_N_PERIODS = 16;
   localparam int unsigned DEFAULT_DATA_W    = 24;

   // Wide enough for M*N_PERIODS full-scale samples of either sign, plus the
   // negated most-negative sample.
   function automatic int unsigned acc_width(input int unsigned data_w,
                                             input int unsigned m,
                                             input int unsigned n_periods);
      return data_w + $clog2(m * n_periods) + 1;
   endfunction

endpackage

// File: rtl/acumulador_signo.sv
// Conditional-negate signed accumulator.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : acc <= 0 (wins over load)
//   load         : acc <= acc +/- data_in
//   negate       : subtract data_in instead of adding it
//   data_in      : signed sample, DATA_W bits
//   acc          : current accumulator value
//   sum          : acc plus the signed term of this cycle (combinational)
module acumulador_signo #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned ACC_W  = 35
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     load,
   input  logic                     negate,
   input  logic signed [DATA_W-1:0] data_in,
   output logic signed [ACC_W-1:0]  acc,
   output logic signed [ACC_W-1:0]  sum
);

   logic signed [ACC_W-1:0] data_ext;
   logic signed [ACC_W-1:0] term;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;

   // Extend before negating so that -(-2^(DATA_W-1)) is representable.
   assign data_ext = {{(ACC_W - DATA_W){data_in[DATA_W-1]}}, data_in};
   assign term     = negate ? -data_ext : data_ext;
   assign sum      = acc_q + term;
   assign acc      = acc_q;

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (load) begin
         acc_d = sum;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/detector_lockin.sv
// Lock-in demodulator: multiplies each sample by +/-1 following the square-wave
// stimulus reference and sums over N_PERIODS periods of M samples, emitting one
// signed result per window through a valid/ready handshake.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : run request; low returns to idle and drops any partial sum
//   data_valid    : strobe qualifying data_in and sinc_ref
//   data_in       : signed sample
//   sinc_ref      : 1 in first half-period, 0 in second
//   result        : last completed window sum
//   result_valid  : result holds an unread value
//   result_ready  : consumer accepts result
//   busy          : aligning or accumulating
//   overrun       : sticky, an unread result was overwritten
module detector_lockin
   import detector_pkg::*;
#(
   parameter int unsigned M         = DEFAULT_M,
   parameter int unsigned N_PERIODS = DEFAULT_N_PERIODS,
   parameter int unsigned DATA_W    = DEFAULT_DATA_W,
   parameter int unsigned ACC_W     = acc_width(DATA_W, M, N_PERIODS)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     data_valid,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic                     sinc_ref,
   output logic signed [ACC_W-1:0]  result,
   output logic                     result_valid,
   input  logic                     result_ready,
   output logic                     busy,
   output logic                     overrun
);

   localparam int unsigned WINDOW = M * N_PERIODS;
   localparam int unsigned CNT_W  = $clog2(WINDOW);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ref_prev_q, ref_prev_d;
   logic signed [ACC_W-1:0] result_q, result_d;
   logic                    result_valid_q, result_valid_d;
   logic                    overrun_q, overrun_d;

   logic                    acc_clear;
   logic                    acc_load;
   logic                    window_done;
   logic signed [ACC_W-1:0] acc_value;
   logic signed [ACC_W-1:0] acc_sum;

   acumulador_signo #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_acc (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (acc_clear),
      .load    (acc_load),
      .negate  (~sinc_ref),
      .data_in (data_in),
      .acc     (acc_value),
      .sum     (acc_sum)
   );

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      ref_prev_d     = ref_prev_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      overrun_d      = overrun_q;
      acc_clear      = 1'b0;
      acc_load       = 1'b0;
      window_done    = 1'b0;

      if (result_valid_q && result_ready) begin
         result_valid_d = 1'b0;
      end

      if (!enable) begin
         state_d    = StIdle;
         cnt_d      = '0;
         ref_prev_d = 1'b1;
         acc_clear  = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_d      = '0;
               ref_prev_d = 1'b1;
               acc_clear  = 1'b1;
               state_d    = StArm;
            end
            StArm: begin
               if (data_valid) begin
                  ref_prev_d = sinc_ref;
                  // Rising reference edge marks sample 0 of the first window.
                  if (sinc_ref && !ref_prev_q) begin
                     state_d  = StAccum;
                     acc_load = 1'b1;
                     cnt_d    = CNT_W'(1);
                  end
               end
            end
            StAccum: begin
               if (data_valid) begin
                  if (cnt_q == CNT_LAST) begin
                     window_done = 1'b1;
                     acc_clear   = 1'b1;
                     cnt_d       = '0;
                  end else begin
                     acc_load = 1'b1;
                     cnt_d    = cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      if (window_done) begin
         result_d       = acc_sum;
         result_valid_d = 1'b1;
         // A simultaneous handshake means the old value was consumed.
         if (result_valid_q && !result_ready) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         ref_prev_q     <= 1'b1;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ref_prev_q     <= ref_prev_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         overrun_q      <= overrun_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign overrun      = overrun_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_detector_lockin.sv
// Directed bench for detector_lockin with M=4, N_PERIODS=2, DATA_W=24 (ACC_W=28).
module tb_detector_lockin;

   localparam int unsigned M         = 4;
   localparam int unsigned N_PERIODS = 2;
   localparam int unsigned DATA_W    = 24;
   localparam int unsigned ACC_W     = 28;

   logic                     clk;
   logic                     reset_n;
   logic                     enable;
   logic                     data_valid;
   logic signed [DATA_W-1:0] data_in;
   logic                     sinc_ref;
   logic signed [ACC_W-1:0]  result;
   logic                     result_valid;
   logic                     result_ready;
   logic                     busy;
   logic                     overrun;

   int n_cmp = 0;
   int n_err = 0;

   detector_lockin #(
      .M         (M),
      .N_PERIODS (N_PERIODS),
      .DATA_W    (DATA_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .data_valid   (data_valid),
      .data_in      (data_in),
      .sinc_ref     (sinc_ref),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .busy         (busy),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      data_valid = 1'b0;
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic send(input logic r, input int d);
      data_valid = 1'b1;
      sinc_ref   = r;
      data_in    = d[DATA_W-1:0];
      step();
      data_valid = 1'b0;
   endtask

   // One aligned window: reference 1,1,0,0 per period. mode 0 = constant amp,
   // mode 1 = +amp in first half, -amp in second. rdy[i] drives result_ready.
   task automatic send_window(input int amp, input int mode, input logic [7:0] rdy);
      logic r;
      int   d;
      for (int i = 0; i < 8; i++) begin
         r            = ((i % 4) < 2);
         d            = (mode == 1 && !r) ? -amp : amp;
         result_ready = rdy[i];
         send(r, d);
      end
      result_ready = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      enable       = 1'b0;
      data_valid   = 1'b0;
      data_in      = '0;
      sinc_ref     = 1'b0;
      result_ready = 1'b0;
      #12;
      check("rst_result", longint'(result), 0);
      check("rst_valid", longint'(result_valid), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_overrun", longint'(overrun), 0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(1);

      // Constant input: +/- halves cancel.
      enable = 1'b1;
      idle(1);
      check("arm_busy", longint'(busy), 1);
      send(1'b0, 100);
      for (int i = 0; i < 8; i++) begin
         send(((i % 4) < 2), 100);
         if (i == 6) check("lat_not_yet", longint'(result_valid), 0);
      end
      check("const_valid", longint'(result_valid), 1);
      check("const_result", longint'(result), 0);
      result_ready = 1'b1;
      idle(1);
      result_ready = 1'b0;
      check("hs_clear", longint'(result_valid), 0);

      // Correlated input, two back-to-back windows.
      send_window(100, 1, 8'h00);
      check("corr_w1", longint'(result), 800);
      send_window(100, 1, 8'h01);
      check("corr_w2", longint'(result), 800);
      check("corr_w2_valid", longint'(result_valid), 1);
      check("corr_w2_ovr", longint'(overrun), 0);

      // Enable drop, then raise mid-period with junk before the edge.
      enable = 1'b0;
      idle(1);
      check("drop_busy", longint'(busy), 0);
      result_ready = 1'b1;
      idle(1);
      result_ready = 1'b0;
      enable = 1'b1;
      send(1'b0, 5000);
      check("midp_busy", longint'(busy), 1);
      send(1'b0, 5000);
      send_window(100, 1, 8'h00);
      check("midp_result", longint'(result), 800);
      result_ready = 1'b1;
      idle(1);
      result_ready = 1'b0;

      // Full-scale negative, both signs, with overrun.
      enable = 1'b0;
      idle(1);
      enable = 1'b1;
      idle(1);
      send(1'b0, 0);
      for (int i = 0; i < 8; i++) send(1'b1, -8388608);
      check("neg_full", longint'(result), -64'sd67108864);
      check("neg_ovr", longint'(overrun), 0);
      for (int i = 0; i < 8; i++) send(1'b0, -8388608);
      check("pos_full", longint'(result), 67108864);
      check("ovr_valid", longint'(result_valid), 1);
      check("ovr_set", longint'(overrun), 1);

      // Asynchronous reset in the middle of a window.
      send(1'b1, 50);
      send(1'b1, 50);
      send(1'b0, 50);
      reset_n = 1'b0;
      enable  = 1'b0;
      #2;
      check("async_result", longint'(result), 0);
      check("async_valid", longint'(result_valid), 0);
      check("async_busy", longint'(busy), 0);
      check("async_overrun", longint'(overrun), 0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(1);

      // New result with a handshake on the same edge: no overrun.
      enable = 1'b1;
      idle(1);
      send(1'b0, 0);
      send_window(7, 1, 8'h00);
      check("hs_w1", longint'(result), 56);
      send_window(1, 1, 8'h80);
      check("hs_w2", longint'(result), 8);
      check("hs_w2_valid", longint'(result_valid), 1);
      check("hs_w2_ovr", longint'(overrun), 0);

      // Drop enable mid-window: partial sum lost, result kept, re-aligned.
      send(1'b1, 1000);
      send(1'b1, 1000);
      send(1'b0, 1000);
      enable = 1'b0;
      send(1'b0, 1000);
      check("part_busy", longint'(busy), 0);
      check("part_result", longint'(result), 8);
      check("part_valid", longint'(result_valid), 1);
      result_ready = 1'b1;
      idle(1);
      result_ready = 1'b0;
      enable = 1'b1;
      idle(1);
      send(1'b0, 0);
      send_window(10, 1, 8'h00);
      check("realign_result", longint'(result), 80);
      check("realign_ovr", longint'(overrun), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/detector_lockin.md
# detector_lockin

Synchronous lock-in demodulator for the SSVEP chain. It consumes the ADS1299 sample stream together with the square-wave stimulus reference produced by the stimulus generator. Each sample is multiplied by ±1 according to the reference and summed over an integer number of stimulus periods. It emits one signed correlation value per integration window through a valid/ready handshake to the readout logic.

## Interface
Parameters:
- M, 64: samples per stimulus period; must be even and ≥ 2; must match the stimulus generator.
- N_PERIODS, 16: stimulus periods per integration window; ≥ 1.
- DATA_W, 24: sample width, signed two's complement.
- ACC_W, DATA_W + clog2(M*N_PERIODS) + 1: accumulator and result width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; low forces IDLE.
- data_valid  in  1  one-cycle strobe; data_in and sinc_ref are valid this cycle.
- data_in  in  DATA_W  signed sample.
- sinc_ref  in  1  stimulus reference: 1 means the first half-period, 0 the second.
- result  out  ACC_W  signed window sum.
- result_valid  out  1  result holds an unread value.
- result_ready  in  1  consumer accepts result.
- busy  out  1  high in ARM or ACCUM.
- overrun  out  1  sticky; a result was overwritten before it was read.

## Operation
- States: IDLE, ARM, ACCUM.
- IDLE:
  - acc=0, cnt=0, ref_prev=1.
  - enable=1 → ARM.
- ARM:
  - On each data_valid, ref_prev<=sinc_ref.
  - A data_valid cycle with sinc_ref=1 and ref_prev=0 is the period start → ACCUM. That sample is accumulated as sample 0.
  - Earlier samples are discarded.
- ACCUM:
  - Each data_valid: acc += sinc_ref ? data_in : −data_in. Sign-extend to ACC_W before negating; −(−2^(DATA_W−1)) must be exact. cnt increments.
  - When cnt reaches M*N_PERIODS−1 with data_valid:
    - result<=acc+term, result_valid<=1.
    - acc<=0, cnt<=0.
    - Stay in ACCUM with no re-alignment; the reference is periodic.
- enable=0 in any state → IDLE next edge. acc and cnt are cleared. result, result_valid and overrun are kept. A sample arriving in the same cycle is discarded.
- Handshake: result_valid && result_ready at an edge clears result_valid.
- New result while result_valid=1 and result_ready=0: result is overwritten, result_valid stays 1, overrun<=1.
- New result and handshake on the same edge: new value loaded, result_valid stays 1, no overrun.
- overrun clears only on reset.
- No arithmetic saturation; ACC_W guarantees no overflow.

## Timing
- Reset values: result=0, result_valid=0, busy=0, overrun=0; state IDLE, acc=0, cnt=0, ref_prev=1.
- Accept rate: one sample per clock; data_valid may be asserted continuously.
- busy: 1 the cycle after the edge that leaves IDLE; 0 the cycle after enable drops.
- Latency: result_valid rises one clk after the edge sampling the window's last data_valid. There are no additional pipeline stages.
- ARM→ACCUM: the qualifying sample is the same one accumulated. No sample is lost at the transition.
- Window wrap: the sample after the last one is sample 0 of the next window in the same cycle flow. There are no gap cycles.
- result is stable whenever result_valid=1 and no new window completes.

## Structure
- Shared package (detector_pkg):
  - State encoding (IDLE=0, ARM=1, ACCUM=2).
  - ACC_W derivation function.
  - Default M/DATA_W constants, also used by the stimulus generator.
- Natural sub-module: acumulador_signo. It holds the conditional-negate signed adder with acc register, clear, and load enable. The top level keeps the FSM, counter, and output handshake.

## Test plan
- M=4, N_PERIODS=2, generator-driven sinc_ref (1,1,0,0), data_in constant 100, data_valid every cycle → result=0, result_valid one clk after the 8th sample.
- Same configuration, data_in = +100 when sinc_ref=1 and −100 when sinc_ref=0 → result=800. The second consecutive window also gives 800, with no gap cycles.
- enable raised mid-period (sinc_ref=0 phase) → busy=1, samples ignored until the 0→1 reference edge. Result matches the aligned case (800).
- data_in=−2^23, sinc_ref held 1 for 8 samples (M=4, N=2 in ARM: prime with one sinc_ref=0 sample first) → result=−2^26 exactly, no wrap (ACC_W=28).
- result_ready held 0 across two windows → result shows the second value, result_valid=1, overrun=1. Repeat with result_ready=1 on the completion edge → overrun stays 0.
- enable dropped in the middle of a window, then reasserted → partial sum discarded, previous result/result_valid retained. The next window is re-aligned. Assert reset_n low mid-ACCUM → all outputs at reset values immediately (asynchronously).
